psram_wb_linebuf: RTL and testbench

PSRAM_WB_LINEBUF -- requirements
Module: psram_wb_linebuf

---
 rtl/psram_wb_linebuf.sv | 224 ++++++++++++++++++++++
 tb/tb_psram_wb_linebuf.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/psram_wb_linebuf.sv
// psram_wb_linebuf: one-line PSRAM cache between a Wishbone slave and a line-transfer engine.
// Define PSRAM_LB_WRITEBACK_EN for write-back; the default build is write-through (write-allocate).
module psram_wb_linebuf #(
    parameter int unsigned LINE_BYTES = 16,
    parameter int unsigned ADDR_W     = 24
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [31:0]             adr_i,
    input  logic [31:0]             dat_i,
    output logic [31:0]             dat_o,
    input  logic [3:0]              sel_i,
    input  logic                    cyc_i,
    input  logic                    stb_i,
    input  logic                    we_i,
    output logic                    ack_o,
    input  logic                    flush_i,
    output logic                    flush_busy_o,
    output logic                    mem_rd_o,
    output logic                    mem_wr_o,
    output logic [ADDR_W-1:0]       mem_addr_o,
    output logic [5:0]              mem_size_o,
    output logic [8*LINE_BYTES-1:0] mem_wdata_o,
    input  logic [8*LINE_BYTES-1:0] mem_rdata_i,
    input  logic                    mem_rd_done_i,
    input  logic                    mem_wr_done_i
);
    localparam int unsigned OFF_W  = $clog2(LINE_BYTES);
    localparam int unsigned TAG_W  = ADDR_W - OFF_W;
    localparam int unsigned WORDS  = LINE_BYTES / 4;
    localparam int unsigned WSEL_W = (OFF_W > 2) ? OFF_W - 2 : 1;
`ifdef PSRAM_LB_WRITEBACK_EN
    localparam bit WB_EN = 1'b1;
`else
    localparam bit WB_EN = 1'b0;
`endif

    typedef enum logic [2:0] {S_IDLE, S_EVICT, S_FILL, S_WTHRU, S_RESP} state_t;

    state_t                     r_state, w_state_n;
    logic                       r_valid, w_valid_n;
    logic                       r_dirty, w_dirty_n;
    logic                       r_flush, w_flush_n;
    logic                       r_flush_busy, w_flush_busy_n;
    logic                       r_ack, w_ack_n;
    logic                       r_mem_rd, w_mem_rd_n;
    logic                       r_mem_wr, w_mem_wr_n;
    logic [TAG_W-1:0]           r_tag, w_tag_n;
    logic [TAG_W-1:0]           r_req_tag, w_req_tag_n;
    logic [ADDR_W-1:0]          r_mem_addr, w_mem_addr_n;
    logic [31:0]                r_dat, w_dat_n;
    logic [WORDS-1:0][31:0]     r_line, w_line_n;

    logic [TAG_W-1:0]           w_adr_tag;
    logic [WSEL_W-1:0]          w_widx;
    logic [3:0][7:0]            w_old_word;
    logic [3:0][7:0]            w_merged;
    logic                       w_hit;
    logic                       w_req;
    logic                       w_unused;

    assign w_adr_tag = adr_i[ADDR_W-1:OFF_W];

    if (OFF_W > 2) begin : g_widx
        assign w_widx = adr_i[OFF_W-1:2];
    end else begin : g_widx_one
        assign w_widx = '0;
    end

    // Byte-lane offset and address bits above the PSRAM range carry no information.
    if (ADDR_W < 32) begin : g_unused_hi
        assign w_unused = ^{adr_i[31:ADDR_W], adr_i[1:0]};
    end else begin : g_unused_lo
        assign w_unused = ^adr_i[1:0];
    end

    assign w_old_word = r_line[w_widx];
    for (genvar b = 0; b < 4; b++) begin : g_merge
        assign w_merged[b] = sel_i[b] ? dat_i[8*b +: 8] : w_old_word[b];
    end

    assign w_hit = r_valid && (r_tag == w_adr_tag);
    // While ack is out the master still holds stb; don't restart the same access.
    assign w_req = cyc_i && stb_i && !r_ack;

    always_comb begin
        w_state_n      = r_state;
        w_valid_n      = r_valid;
        w_dirty_n      = r_dirty;
        w_flush_n      = r_flush;
        w_flush_busy_n = r_flush_busy;
        w_ack_n        = 1'b0;
        w_mem_rd_n     = 1'b0;
        w_mem_wr_n     = 1'b0;
        w_tag_n        = r_tag;
        w_req_tag_n    = r_req_tag;
        w_mem_addr_n   = r_mem_addr;
        w_dat_n        = r_dat;
        w_line_n       = r_line;
        unique case (r_state)
            S_IDLE: begin
                w_flush_busy_n = 1'b0;
                if (flush_i) begin
                    w_flush_busy_n = 1'b1;
                    if (r_valid && r_dirty) begin
                        w_state_n    = S_EVICT;
                        w_flush_n    = 1'b1;
                        w_mem_wr_n   = 1'b1;
                        w_mem_addr_n = {r_tag, OFF_W'(0)};
                    end else begin
                        w_valid_n = 1'b0;
                    end
                end else if (w_req) begin
                    if (w_hit && we_i) begin
                        w_line_n[w_widx] = w_merged;
                        if (WB_EN) begin
                            if (sel_i != 4'b0000) begin
                                w_dirty_n = 1'b1;
                            end
                            w_state_n = S_RESP;
                        end else begin
                            w_state_n    = S_WTHRU;
                            w_mem_wr_n   = 1'b1;
                            w_mem_addr_n = {r_tag, OFF_W'(0)};
                        end
                    end else if (w_hit) begin
                        w_dat_n   = w_old_word;
                        w_state_n = S_RESP;
                    end else if (r_valid && r_dirty) begin
                        w_state_n    = S_EVICT;
                        w_flush_n    = 1'b0;
                        w_req_tag_n  = w_adr_tag;
                        w_mem_wr_n   = 1'b1;
                        w_mem_addr_n = {r_tag, OFF_W'(0)};
                    end else begin
                        w_state_n    = S_FILL;
                        w_mem_rd_n   = 1'b1;
                        w_mem_addr_n = {w_adr_tag, OFF_W'(0)};
                    end
                end
            end
            S_EVICT: begin
                if (mem_wr_done_i) begin
                    w_dirty_n = 1'b0;
                    if (r_flush) begin
                        w_valid_n      = 1'b0;
                        w_flush_busy_n = 1'b0;
                        w_state_n      = S_IDLE;
                    end else begin
                        w_state_n    = S_FILL;
                        w_mem_rd_n   = 1'b1;
                        w_mem_addr_n = {r_req_tag, OFF_W'(0)};
                    end
                end
            end
            S_FILL: begin
                if (mem_rd_done_i) begin
                    w_line_n  = mem_rdata_i;
                    w_tag_n   = r_mem_addr[ADDR_W-1:OFF_W];
                    w_valid_n = 1'b1;
                    w_dirty_n = 1'b0;
                    w_state_n = S_IDLE;
                end
            end
            S_WTHRU: begin
                if (mem_wr_done_i) begin
                    w_state_n = S_RESP;
                end
            end
            S_RESP: begin
                w_ack_n   = cyc_i && stb_i;
                w_state_n = S_IDLE;
            end
            default: begin
                w_state_n = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state      <= S_IDLE;
            r_valid      <= 1'b0;
            r_dirty      <= 1'b0;
            r_flush      <= 1'b0;
            r_flush_busy <= 1'b0;
            r_ack        <= 1'b0;
            r_mem_rd     <= 1'b0;
            r_mem_wr     <= 1'b0;
            r_tag        <= '0;
            r_req_tag    <= '0;
            r_mem_addr   <= '0;
            r_dat        <= '0;
        end else begin
            r_state      <= w_state_n;
            r_valid      <= w_valid_n;
            r_dirty      <= w_dirty_n;
            r_flush      <= w_flush_n;
            r_flush_busy <= w_flush_busy_n;
            r_ack        <= w_ack_n;
            r_mem_rd     <= w_mem_rd_n;
            r_mem_wr     <= w_mem_wr_n;
            r_tag        <= w_tag_n;
            r_req_tag    <= w_req_tag_n;
            r_mem_addr   <= w_mem_addr_n;
            r_dat        <= w_dat_n;
        end
    end

    // Line storage has no reset; valid guards it.
    always_ff @(posedge clk_i) begin
        r_line <= w_line_n;
    end

    assign dat_o        = r_dat;
    assign ack_o        = r_ack;
    assign flush_busy_o = r_flush_busy;
    assign mem_rd_o     = r_mem_rd;
    assign mem_wr_o     = r_mem_wr;
    assign mem_addr_o   = r_mem_addr;
    assign mem_size_o   = 6'(LINE_BYTES);
    assign mem_wdata_o  = r_line;

endmodule

// File: tb/tb_psram_wb_linebuf.sv
// Randomized self-checking bench for psram_wb_linebuf against a one-line cache model
// plus a PSRAM engine responder; follows PSRAM_LB_WRITEBACK_EN like the design.
module tb_psram_wb_linebuf;
    localparam int unsigned LINE_BYTES = 16;
    localparam int unsigned ADDR_W     = 24;
`ifdef PSRAM_LB_WRITEBACK_EN
    localparam bit WB = 1'b1;
`else
    localparam bit WB = 1'b0;
`endif

    typedef logic [3:0][31:0] line_t;
    typedef struct {
        bit          wr;
        logic [23:0] addr;
        line_t       data;
    } op_t;

    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic [31:0] adr_i = '0;
    logic [31:0] dat_i = '0;
    logic [31:0] dat_o;
    logic [3:0]  sel_i = '0;
    logic        cyc_i = 1'b0;
    logic        stb_i = 1'b0;
    logic        we_i = 1'b0;
    logic        ack_o;
    logic        flush_i = 1'b0;
    logic        flush_busy_o;
    logic        mem_rd_o;
    logic        mem_wr_o;
    logic [23:0] mem_addr_o;
    logic [5:0]  mem_size_o;
    logic [127:0] mem_wdata_o;
    logic [127:0] mem_rdata_i = '0;
    logic        mem_rd_done_i = 1'b0;
    logic        mem_wr_done_i = 1'b0;

    psram_wb_linebuf #(.LINE_BYTES(LINE_BYTES), .ADDR_W(ADDR_W)) dut (
        .clk_i(clk), .rst_i(rst_i), .adr_i(adr_i), .dat_i(dat_i), .dat_o(dat_o),
        .sel_i(sel_i), .cyc_i(cyc_i), .stb_i(stb_i), .we_i(we_i), .ack_o(ack_o),
        .flush_i(flush_i), .flush_busy_o(flush_busy_o),
        .mem_rd_o(mem_rd_o), .mem_wr_o(mem_wr_o), .mem_addr_o(mem_addr_o),
        .mem_size_o(mem_size_o), .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i),
        .mem_rd_done_i(mem_rd_done_i), .mem_wr_done_i(mem_wr_done_i)
    );

    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_miss = 0;

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference state: PSRAM contents and the single cached line.
    line_t       mem [int unsigned];
    op_t         exp_q[$];
    bit          m_valid = 1'b0;
    bit          m_dirty = 1'b0;
    logic [23:0] m_tag = '0;
    line_t       m_line = '0;

    function automatic line_t line_init(input logic [23:0] a);
        line_t l;
        for (int w = 0; w < 4; w++) begin
            l[2'(w)] = 32'(a) * 32'h9E3779B1 + 32'(w) * 32'h01010101;
        end
        return l;
    endfunction

    function automatic line_t mem_line(input logic [23:0] a);
        if (mem.exists(32'(a))) return mem[32'(a)];
        return line_init(a);
    endfunction

    task automatic predict(input logic [31:0] a, input bit we, input logic [31:0] d,
                           input logic [3:0] sel, output bit hit, output logic [31:0] rd);
        logic [23:0] la;
        logic [1:0]  wi;
        logic [31:0] mask;
        la   = {a[23:4], 4'h0};
        wi   = a[3:2];
        hit  = m_valid && (m_tag == la);
        if (!hit) begin
            if (WB && m_valid && m_dirty) begin
                exp_q.push_back('{1'b1, m_tag, m_line});
                mem[32'(m_tag)] = m_line;
            end
            m_line  = mem_line(la);
            exp_q.push_back('{1'b0, la, m_line});
            m_tag   = la;
            m_valid = 1'b1;
            m_dirty = 1'b0;
        end
        if (we) begin
            mask = {{8{sel[3]}}, {8{sel[2]}}, {8{sel[1]}}, {8{sel[0]}}};
            m_line[wi] = (m_line[wi] & ~mask) | (d & mask);
            if (WB) begin
                if (sel != 4'b0000) m_dirty = 1'b1;
            end else begin
                exp_q.push_back('{1'b1, la, m_line});
                mem[32'(la)] = m_line;
            end
        end
        rd = m_line[wi];
    endtask

    // PSRAM engine: checks each request against the model, answers after a random delay.
    bit          eng_busy = 1'b0;
    bit          eng_wr = 1'b0;
    bit          eng_stall = 1'b0;
    int          eng_cnt = 0;
    line_t       eng_line = '0;
    always @(negedge clk) begin
        op_t o;
        mem_rd_done_i = 1'b0;
        mem_wr_done_i = 1'b0;
        mem_rdata_i   = {$urandom, $urandom, $urandom, $urandom};
        if (rst_i) begin
            eng_busy = 1'b0;
        end else if (mem_rd_o || mem_wr_o) begin
            check_eq("eng_rd_wr_exclusive", 128'(mem_rd_o && mem_wr_o), 128'(0));
            check_eq("eng_req_while_busy", 128'(eng_busy), 128'(0));
            check_eq("eng_op_expected", 128'(exp_q.size() != 0), 128'(1));
            eng_line = line_t'({$urandom, $urandom, $urandom, $urandom});
            if (exp_q.size() != 0) begin
                o = exp_q.pop_front();
                check_eq("eng_op_is_write", 128'(mem_wr_o), 128'(o.wr));
                check_eq("eng_op_addr", 128'(mem_addr_o), 128'(o.addr));
                if (o.wr) check_eq("eng_wdata", 128'(mem_wdata_o), 128'(o.data));
                eng_line = o.data;
            end
            eng_busy = 1'b1;
            eng_wr   = mem_wr_o;
            eng_cnt  = $urandom_range(1, 4);
        end else if (eng_busy) begin
            if (eng_cnt > 0) begin
                eng_cnt--;
            end else if (!eng_stall) begin
                if (eng_wr) begin
                    mem_wr_done_i = 1'b1;
                end else begin
                    mem_rd_done_i = 1'b1;
                    mem_rdata_i   = eng_line;
                end
                eng_busy = 1'b0;
            end
        end else if ($urandom_range(0, 7) == 0) begin
            if ($urandom_range(0, 1) == 1) mem_rd_done_i = 1'b1;
            else mem_wr_done_i = 1'b1;
        end
    end

    task automatic wb_access(input logic [31:0] a, input bit we, input logic [31:0] d,
                             input logic [3:0] sel, output logic [31:0] got);
        bit          hit;
        bit          seen;
        int          n;
        logic [31:0] exp_rd;
        predict(a, we, d, sel, hit, exp_rd);
        @(negedge clk);
        adr_i = a; dat_i = d; sel_i = sel; we_i = we; cyc_i = 1'b1; stb_i = 1'b1;
        n = 0;
        seen = 1'b0;
        while (!seen && n < 200) begin
            @(negedge clk);
            n++;
            seen = ack_o;
        end
        got = dat_o;
        check_eq("ack_seen", 128'(seen), 128'(1));
        if (!we) check_eq("rd_data", 128'(got), 128'(exp_rd));
        if (hit && (WB || !we)) check_eq("hit_latency", 128'(n), 128'(2));
        cyc_i = 1'b0; stb_i = 1'b0;
        @(negedge clk);
        check_eq("ack_one_cycle", 128'(ack_o), 128'(0));
        check_eq("engine_ops_done", 128'(exp_q.size()), 128'(0));
    endtask

    task automatic do_flush();
        int n;
        if (WB && m_valid && m_dirty) begin
            exp_q.push_back('{1'b1, m_tag, m_line});
            mem[32'(m_tag)] = m_line;
        end
        m_valid = 1'b0;
        m_dirty = 1'b0;
        @(negedge clk);
        flush_i = 1'b1;
        @(negedge clk);
        check_eq("flush_busy_rise", 128'(flush_busy_o), 128'(1));
        flush_i = 1'b0;
        n = 0;
        while (flush_busy_o && n < 200) begin
            @(negedge clk);
            n++;
        end
        check_eq("flush_busy_fall", 128'(flush_busy_o), 128'(0));
        check_eq("flush_ops_done", 128'(exp_q.size()), 128'(0));
    endtask

    // Read hit whose strobe drops while the response is pending: no ack.
    task automatic wb_abort_hit(input logic [31:0] a);
        bit seen;
        @(negedge clk);
        adr_i = a; we_i = 1'b0; sel_i = 4'hF; cyc_i = 1'b1; stb_i = 1'b1;
        @(negedge clk);
        cyc_i = 1'b0; stb_i = 1'b0;
        seen = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (ack_o) seen = 1'b1;
        end
        check_eq("abort_hit_no_ack", 128'(seen), 128'(0));
    endtask

    // Miss whose strobe drops mid-fill: the fill still completes, no ack.
    task automatic wb_abort_fill(input logic [31:0] a);
        bit          hit;
        bit          seen;
        int          n;
        logic [31:0] rd;
        predict(a, 1'b0, 32'h0, 4'hF, hit, rd);
        @(negedge clk);
        adr_i = a; we_i = 1'b0; sel_i = 4'hF; cyc_i = 1'b1; stb_i = 1'b1;
        n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check_eq("abort_fill_issued", 128'(exp_q.size()), 128'(0));
        cyc_i = 1'b0; stb_i = 1'b0;
        seen = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (ack_o) seen = 1'b1;
        end
        check_eq("abort_fill_no_ack", 128'(seen), 128'(0));
    endtask

    task automatic reset_in_fill(input logic [31:0] a);
        bit          hit;
        int          n;
        logic [31:0] rd;
        eng_stall = 1'b1;
        predict(a, 1'b0, 32'h0, 4'hF, hit, rd);
        @(negedge clk);
        adr_i = a; we_i = 1'b0; sel_i = 4'hF; cyc_i = 1'b1; stb_i = 1'b1;
        n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check_eq("rst_fill_issued", 128'(exp_q.size()), 128'(0));
        @(negedge clk);
        rst_i = 1'b1;
        #1;
        check_eq("rst_ack", 128'(ack_o), 128'(0));
        check_eq("rst_mem_rd", 128'(mem_rd_o), 128'(0));
        check_eq("rst_mem_wr", 128'(mem_wr_o), 128'(0));
        check_eq("rst_flush_busy", 128'(flush_busy_o), 128'(0));
        check_eq("rst_dat", 128'(dat_o), 128'(0));
        @(negedge clk);
        rst_i = 1'b0; cyc_i = 1'b0; stb_i = 1'b0;
        eng_stall = 1'b0;
        m_valid = 1'b0;
        m_dirty = 1'b0;
    endtask

    initial begin
        logic [31:0] got;
        logic [23:0] lines [4];
        logic [31:0] a;
        int          r;
        lines[0] = 24'h000100; lines[1] = 24'h000200;
        lines[2] = 24'h7FFF40; lines[3] = 24'hFFFFF0;
        mem[32'h100] = {4{32'h11111111}};

        repeat (3) @(negedge clk);
        check_eq("reset_ack", 128'(ack_o), 128'(0));
        check_eq("reset_mem_rd", 128'(mem_rd_o), 128'(0));
        check_eq("reset_mem_wr", 128'(mem_wr_o), 128'(0));
        check_eq("reset_flush_busy", 128'(flush_busy_o), 128'(0));
        check_eq("reset_dat", 128'(dat_o), 128'(0));
        check_eq("mem_size", 128'(mem_size_o), 128'(16));
        rst_i = 1'b0;

        wb_access(32'h0000_0100, 1'b0, 32'h0, 4'hF, got);
        check_eq("first_read_word0", 128'(got), 128'(32'h11111111));
        wb_access(32'h0000_0104, 1'b1, 32'hAABBCCDD, 4'b0101, got);
        wb_access(32'h0000_0104, 1'b0, 32'h0, 4'hF, got);
        check_eq("merged_word", 128'(got), 128'(32'h11BB11DD));
        wb_access(32'h0000_0200, 1'b0, 32'h0, 4'hF, got);
        wb_access(32'h0000_0208, 1'b1, 32'hCAFEF00D, 4'hF, got);
        do_flush();
        wb_access(32'h0000_0208, 1'b0, 32'h0, 4'hF, got);
        do_flush();
        do_flush();
        wb_access(32'h0000_0300, 1'b0, 32'h0, 4'hF, got);
        wb_access(32'h0000_0300, 1'b1, 32'h12345678, 4'b0000, got);
        wb_access(32'h0000_0400, 1'b0, 32'h0, 4'hF, got);
        wb_abort_hit(32'h0000_0408);
        wb_abort_fill(32'h0000_0500);
        wb_access(32'h0000_050C, 1'b0, 32'h0, 4'hF, got);
        do_flush();
        reset_in_fill(32'h0000_0600);
        wb_access(32'h0000_0604, 1'b0, 32'h0, 4'hF, got);

        for (int i = 0; i < 300; i++) begin
            r = $urandom_range(0, 15);
            a = {8'($urandom), lines[$urandom_range(0, 3)][23:4], 2'($urandom), 2'($urandom)};
            if (r == 0) do_flush();
            else wb_access(a, r < 7, $urandom, 4'($urandom), got);
        end

        repeat (5) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
